// File: rtl/psum_accum_engine_if.sv
// OFIFO drain stream and external PSUM row-read port of the partial-sum accumulation engine.
// The engine binds the slave modport; the OFIFO/readout side binds the master modport.
interface psum_accum_engine_if #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_bw = 6
);
  logic                     ofifo_valid;
  logic [col*psum_bw-1:0]   ofifo_out;
  logic                     ofifo_rd;
  logic                     rd_en;
  logic [addr_bw-1:0]       rd_addr;
  logic [col*psum_bw-1:0]   rd_data;
  logic                     rd_valid;

  modport master (
    output ofifo_valid, ofifo_out, rd_en, rd_addr,
    input  ofifo_rd, rd_data, rd_valid
  );

  modport slave (
    input  ofifo_valid, ofifo_out, rd_en, rd_addr,
    output ofifo_rd, rd_data, rd_valid
  );
endinterface

// File: rtl/psum_accum_engine.sv
// Autonomous PSUM accumulation engine: drains OFIFO rows, read-modify-writes the PSUM store
// with per-lane saturation and optional ReLU, and serves external row reads while idle.
module psum_accum_engine #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 64,
  parameter int addr_bw = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [addr_bw:0]   num_rows,
  psum_accum_engine_if.slave bus,
  output logic               busy,
  output logic               done,
  output logic               sat_flag
);
  localparam int row_bw = col * psum_bw;

  typedef enum logic [1:0] {IDLE, FETCH, ACC, DONE} state_e;

  state_e               state_q, state_d;
  logic [addr_bw-1:0]   ptr_q, ptr_d;
  logic [1:0]           mode_q, mode_d;
  logic [addr_bw:0]     rows_q, rows_d;
  logic [row_bw-1:0]    stage_q, stage_d;
  logic [row_bw-1:0]    mem_rd_q, mem_rd_d;
  logic [row_bw-1:0]    rd_data_q, rd_data_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 sat_q, sat_d;

  logic [row_bw-1:0]    mem [depth];
  logic [row_bw-1:0]    acc_row;
  logic                 acc_sat;
  logic                 wr_en;
  logic                 last_row;

  // Lane datapath: widen by one bit, clamp on overflow, then optional ReLU.
  always_comb begin
    logic [psum_bw:0]   sum;
    logic [psum_bw-1:0] lane;
    sum     = '0;
    lane    = '0;
    acc_row = '0;
    acc_sat = 1'b0;
    for (int i = 0; i < col; i++) begin
      lane = (mode_q == 2'b00) ? '0 : mem_rd_q[i*psum_bw +: psum_bw];
      sum  = {stage_q[(i+1)*psum_bw-1], stage_q[i*psum_bw +: psum_bw]}
           + {lane[psum_bw-1], lane};
      if (sum[psum_bw] != sum[psum_bw-1]) begin
        acc_sat = 1'b1;
        lane    = sum[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
      end else begin
        lane = sum[psum_bw-1:0];
      end
      if (mode_q == 2'b10 && lane[psum_bw-1]) lane = '0;
      acc_row[i*psum_bw +: psum_bw] = lane;
    end
  end

  assign last_row = ({1'b0, ptr_q} == rows_q - (addr_bw+1)'(1));

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    state_d    = state_q;
    ptr_d      = ptr_q;
    mode_d     = mode_q;
    rows_d     = rows_q;
    stage_d    = stage_q;
    mem_rd_d   = mem_rd_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    sat_d      = sat_q;
    wr_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mode_d = mode;
          rows_d = num_rows;
          sat_d  = 1'b0;
          ptr_d  = '0;
          if (num_rows == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = FETCH;
          end
        end
        if (bus.rd_en) begin
          rd_valid_d = 1'b1;
          rd_data_d  = (int'(bus.rd_addr) < depth) ? mem[bus.rd_addr] : '0;
        end
      end
      FETCH: begin
        if (bus.ofifo_valid) begin
          stage_d  = bus.ofifo_out;
          mem_rd_d = mem[ptr_q];
          state_d  = ACC;
        end
      end
      ACC: begin
        wr_en = 1'b1;
        sat_d = sat_q | acc_sat;
        if (last_row) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          ptr_d   = ptr_q + addr_bw'(1);
          state_d = FETCH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // The pop follows the live valid so it lands on the same edge that captures the row.
  assign bus.ofifo_rd = (state_q == FETCH) && bus.ofifo_valid;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      mode_q     <= '0;
      rows_q     <= '0;
      stage_q    <= '0;
      mem_rd_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      mode_q     <= mode_d;
      rows_q     <= rows_d;
      stage_q    <= stage_d;
      mem_rd_q   <= mem_rd_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sat_q      <= sat_d;
    end
  end

  // NOTE: the store is deliberately not reset; its rows survive reset, and a reset cycle blocks the write.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem[ptr_q] <= acc_row;
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign sat_flag     = sat_q;
endmodule

// File: tb/tb_psum_accum_engine.sv
// Bench for psum_accum_engine: directed vector table, hand-written interlock/reset sequences,
// and randomized passes checked against an integer-arithmetic model of the PSUM store.
module tb_psum_accum_engine;
  localparam int COL   = 8;
  localparam int PB    = 16;
  localparam int DEPTH = 64;
  localparam int AB    = 6;
  localparam int W     = COL * PB;
  localparam int PMAX  = (1 << (PB - 1)) - 1;
  localparam int PMIN  = -(1 << (PB - 1));

  typedef logic [2:0][PB-1:0] trip_t;
  typedef struct packed {
    logic [1:0] mode;
    logic [7:0] rows;
    logic [7:0] stall;
    trip_t      ev, od, xev, xod;
    logic       xsat;
    logic [7:0] xcyc;
  } vec_t;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [1:0]     mode = 2'b00;
  logic [AB:0]    num_rows = '0;
  logic           busy, done, sat_flag;

  int             n_checks = 0;
  int             n_errors = 0;

  logic [W-1:0]   fifo_q[$];
  logic [W-1:0]   pend_rows[$];
  logic [W-1:0]   model_mem [DEPTH];
  logic [W-1:0]   last_rd = '0;
  int             pop_count = 0;
  int             stall_at = 0;
  int             stall_len = 0;
  int             stall_cnt = 0;
  bit             stall_pend = 0;
  bit             rand_stall = 0;
  bit             rd_seen = 0;

  psum_accum_engine_if #(.col(COL), .psum_bw(PB), .addr_bw(AB)) bus ();

  psum_accum_engine #(.col(COL), .psum_bw(PB), .depth(DEPTH), .addr_bw(AB)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mode     (mode),
    .num_rows (num_rows),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .sat_flag (sat_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference store update: plain integer arithmetic per lane.
  function automatic logic [W-1:0] model_row(input logic [1:0] m, input logic [W-1:0] in_row,
                                             input logic [W-1:0] old, output bit sat);
    logic [W-1:0]  r;
    logic [PB-1:0] la, lb;
    int            a, b, s;
    sat = 0;
    r   = '0;
    for (int i = 0; i < COL; i++) begin
      la = in_row[i*PB +: PB];
      lb = old[i*PB +: PB];
      a  = $signed(la);
      b  = (m == 2'b00) ? 0 : $signed(lb);
      s  = a + b;
      if (s > PMAX) begin s = PMAX; sat = 1; end
      else if (s < PMIN) begin s = PMIN; sat = 1; end
      if (m == 2'b10 && s < 0) s = 0;
      r[i*PB +: PB] = PB'(s);
    end
    return r;
  endfunction

  function automatic trip_t r3(input int a, input int b, input int c);
    trip_t t;
    t[0] = PB'(a);
    t[1] = PB'(b);
    t[2] = PB'(c);
    return t;
  endfunction

  function automatic logic [W-1:0] mk_row(input int ev, input int od);
    logic [W-1:0] r;
    for (int i = 0; i < COL; i++) r[i*PB +: PB] = PB'((i % 2 == 0) ? ev : od);
    return r;
  endfunction

  // OFIFO model: presents the head row, pops on a seen ofifo_rd, inserts scripted or random stalls.
  initial begin
    bus.ofifo_valid = 1'b0;
    bus.ofifo_out   = '0;
    forever begin
      @(negedge clk);
      rd_seen = (bus.ofifo_rd === 1'b1);
      if (rd_seen) check("rd_needs_valid", W'(bus.ofifo_valid), W'(1));
      @(posedge clk);
      #2;
      if (stall_pend) begin
        stall_cnt  = stall_len;
        stall_pend = 0;
      end
      if (rd_seen) begin
        pop_count++;
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (pop_count == stall_at) stall_pend = 1;
      end
      bus.ofifo_valid = (fifo_q.size() > 0) && (stall_cnt == 0)
                        && !(rand_stall && $urandom_range(0, 3) == 0);
      bus.ofifo_out   = (fifo_q.size() > 0) ? fifo_q[0] : '0;
      if (stall_cnt > 0) stall_cnt--;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] m, input int n);
    tick();
    start    = 1'b1;
    mode     = m;
    num_rows = (AB+1)'(n);
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check("busy_in_pass", W'(busy), W'(1));
    end while (done !== 1'b1 && cyc < 3000);
    check("done_seen", W'(done), W'(1));
    @(negedge clk);
    check("done_one_cycle", W'(done), W'(0));
    check("idle_after_done", W'(busy), W'(0));
  endtask

  task automatic read_row(input int addr, output logic [W-1:0] data);
    tick();
    bus.rd_en   = 1'b1;
    bus.rd_addr = AB'(addr);
    tick();
    bus.rd_en   = 1'b0;
    @(negedge clk);
    check("rd_valid", W'(bus.rd_valid), W'(1));
    data    = bus.rd_data;
    last_rd = data;
  endtask

  task automatic apply_model(input logic [1:0] m, input int n, output bit msat);
    bit s;
    msat = 0;
    for (int r = 0; r < n; r++) begin
      model_mem[r] = model_row(m, pend_rows[r], model_mem[r], s);
      msat |= s;
    end
    pend_rows.delete();
  endtask

  task automatic run_pass(input logic [1:0] m, input int n, output int cyc);
    bit msat;
    pop_count = 0;
    foreach (pend_rows[r]) fifo_q.push_back(pend_rows[r]);
    do_start(m, n);
    wait_done(cyc);
    apply_model(m, n, msat);
    check("sat_flag_model", W'(sat_flag), W'(msat));
    check("pop_count", W'(pop_count), W'(n));
  endtask

  vec_t         vecs[7];
  logic [W-1:0] d;
  int           cyc;
  bit           msat;

  initial begin
    // Row triplets are (row0, row1, row2); ev/od are the even/odd lane values.
    vecs[0] = '{mode:2'b00, rows:8'd3, stall:8'd0, ev:r3(5,6,7),   od:r3(5,6,7),
                xev:r3(5,6,7),    xod:r3(5,6,7),     xsat:1'b0, xcyc:8'd7};
    vecs[1] = '{mode:2'b01, rows:8'd3, stall:8'd0, ev:r3(5,6,7),   od:r3(5,6,7),
                xev:r3(10,12,14), xod:r3(10,12,14),  xsat:1'b0, xcyc:8'd7};
    vecs[2] = '{mode:2'b11, rows:8'd1, stall:8'd0, ev:r3(1,0,0),   od:r3(-1,0,0),
                xev:r3(11,0,0),   xod:r3(9,0,0),     xsat:1'b0, xcyc:8'd3};
    vecs[3] = '{mode:2'b00, rows:8'd1, stall:8'd0, ev:r3(32000,0,0), od:r3(-32000,0,0),
                xev:r3(32000,0,0), xod:r3(-32000,0,0), xsat:1'b0, xcyc:8'd3};
    vecs[4] = '{mode:2'b10, rows:8'd1, stall:8'd0, ev:r3(1000,0,0), od:r3(-1000,0,0),
                xev:r3(32767,0,0), xod:r3(0,0,0),    xsat:1'b1, xcyc:8'd3};
    vecs[5] = '{mode:2'b00, rows:8'd3, stall:8'd4, ev:r3(5,6,7),   od:r3(5,6,7),
                xev:r3(5,6,7),    xod:r3(5,6,7),     xsat:1'b0, xcyc:8'd11};
    vecs[6] = '{mode:2'b01, rows:8'd0, stall:8'd0, ev:r3(0,0,0),   od:r3(0,0,0),
                xev:r3(0,0,0),    xod:r3(0,0,0),     xsat:1'b0, xcyc:8'd1};

    bus.rd_en   = 1'b0;
    bus.rd_addr = '0;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_sat", W'(sat_flag), W'(0));
    check("rst_rd_valid", W'(bus.rd_valid), W'(0));
    check("rst_rd_data", bus.rd_data, '0);
    check("rst_ofifo_rd", W'(bus.ofifo_rd), W'(0));

    for (int k = 0; k < 7; k++) begin
      for (int r = 0; r < int'(vecs[k].rows); r++)
        pend_rows.push_back(mk_row(int'(vecs[k].ev[r]), int'(vecs[k].od[r])));
      stall_at  = (vecs[k].stall != 0) ? 1 : 0;
      stall_len = int'(vecs[k].stall);
      run_pass(vecs[k].mode, int'(vecs[k].rows), cyc);
      check("pass_cycles", W'(cyc), W'(vecs[k].xcyc));
      check("sat_expected", W'(sat_flag), W'(vecs[k].xsat));
      for (int r = 0; r < int'(vecs[k].rows); r++) begin
        read_row(r, d);
        check("row_data", d, mk_row(int'(vecs[k].xev[r]), int'(vecs[k].xod[r])));
      end
    end
    stall_at  = 0;
    stall_len = 0;

    // Start and rd_en during a pass are ignored; a decoy row reveals any second pass.
    pop_count = 0;
    pend_rows.push_back(mk_row(100, 100));
    pend_rows.push_back(mk_row(200, 200));
    foreach (pend_rows[r]) fifo_q.push_back(pend_rows[r]);
    fifo_q.push_back(mk_row(9, 9));
    do_start(2'b01, 2);
    bus.rd_en   = 1'b1;
    bus.rd_addr = '0;
    start       = 1'b1;
    mode        = 2'b00;
    num_rows    = (AB+1)'(1);
    tick();
    bus.rd_en = 1'b0;
    start     = 1'b0;
    @(negedge clk);
    check("busy_rd_valid", W'(bus.rd_valid), W'(0));
    check("busy_rd_hold", bus.rd_data, last_rd);
    wait_done(cyc);
    tick();
    tick();
    check("no_second_pass", W'(busy), W'(0));
    check("interlock_pops", W'(pop_count), W'(2));
    apply_model(2'b01, 2, msat);
    fifo_q.delete();
    for (int r = 0; r < 2; r++) begin
      read_row(r, d);
      check("interlock_row", d, model_mem[r]);
    end

    // Reset during the ACC cycle of row 1: row 0 written and saturated, row 1 untouched.
    pop_count = 0;
    fifo_q.push_back(mk_row(32767, 32767));
    fifo_q.push_back(mk_row(3, 3));
    fifo_q.push_back(mk_row(4, 4));
    do_start(2'b01, 3);
    tick();
    tick();
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("sat_before_reset", W'(sat_flag), W'(1));
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", W'(busy), W'(0));
    check("mid_rst_ofifo_rd", W'(bus.ofifo_rd), W'(0));
    check("mid_rst_sat", W'(sat_flag), W'(0));
    check("mid_rst_done", W'(done), W'(0));
    check("mid_rst_rd_data", bus.rd_data, '0);
    model_mem[0] = model_row(2'b01, mk_row(32767, 32767), model_mem[0], msat);
    fifo_q.delete();
    read_row(0, d);
    check("rst_row0_written", d, model_mem[0]);
    read_row(1, d);
    check("rst_row1_kept", d, model_mem[1]);

    // Randomized passes; the first overwrites the whole store so the model knows every row.
    for (int p = 0; p < 12; p++) begin
      logic [1:0]    m;
      int            n;
      logic [W-1:0]  row;
      logic [PB-1:0] lv;
      m          = (p == 0) ? 2'b00 : 2'($urandom_range(0, 3));
      n          = (p == 0 || $urandom_range(0, 4) == 0) ? DEPTH : int'($urandom_range(1, 10));
      rand_stall = (p > 0) && ($urandom_range(0, 1) == 1);
      for (int r = 0; r < n; r++) begin
        for (int i = 0; i < COL; i++) begin
          lv = ($urandom_range(0, 2) == 0) ? PB'($urandom())
                                            : PB'($urandom_range(0, 4000) - 2000);
          row[i*PB +: PB] = lv;
        end
        pend_rows.push_back(row);
      end
      run_pass(m, n, cyc);
      if (!rand_stall) check("rand_cycles", W'(cyc), W'(2 * n + 1));
      rand_stall = 0;
      for (int r = 0; r < n; r++) begin
        read_row(r, d);
        check("rand_row", d, model_mem[r]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
